ioblock_out_ser: RTL
====================

Name: ioblock_out_ser

Overview:
- Output-side counterpart of the input IO tile: drives PIN from fabric data and does not capture from it.
- Programmable through a bit-serial config chain (daisy-chained between tiles), committed with a load strobe.
- Supports direct or registered output, optional inversion, four tristate modes, and 2:1/4:1 parallel-to-serial output with a valid/ready handshake.

Parameters:
- SER_W, 4, maximum serialization width; OD width.
- CFG_BITS, 6, config chain length (7 when parity is compiled in).

Ports:
- IOCLK  input  1  sole clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- PIN  inout  1  pad; driven or high-Z.
- OD  input  SER_W  parallel output data; bit0 goes out first.
- OVALID  input  1  OD word valid.
- OREADY  output  1  block accepts OD this cycle.
- TS  input  1  fabric tristate control.
- BUSY  output  1  serializer in SHIFT state.
- CFG_EN  input  1  shift the config chain this cycle.
- CFG_DIN  input  1  config serial in.
- CFG_DOUT  output  1  config serial out (shadow bit0), feeds the next tile.
- CFG_LOAD  input  1  commit shadow to active config.

Behaviour:
- Config field layout, applying to both shadow and active config:
  - [1:0] TSMUX.
  - [2] OREG.
  - [3] OINV.
  - [5:4] SERMODE: 00 bypass, 01 = 2:1, 10 = 4:1, 11 treated as 4:1.
- Config shifting:
  - When CFG_EN=1: shadow <= {CFG_DIN, shadow[CFG_BITS-1:1]}. LSB is shifted first; after CFG_BITS shifts, the first bit sits in bit0 and appears on CFG_DOUT.
  - CFG_LOAD is ignored in any cycle with CFG_EN=1.
- Config commit:
  - With BUSY=0, CFG_LOAD copies shadow to active at the next edge.
  - With BUSY=1, a pending flag is set and the copy happens on the edge where the serializer returns to IDLE. The word in flight always completes under the old config.
  - A repeated CFG_LOAD while pending keeps one pending flag; the latest shadow is used.
- Reset (RST=1 at edge):
  - Shadow, active config, pending flag, shift register, counter, output flop and TS flop all clear; FSM goes to IDLE.
  - While RST=1, OREADY=0.
  - After reset: PIN=Z (TSMUX=00), OREADY=1, BUSY=0, CFG_DOUT=0.
  - Reset mid-shift discards the word in flight.
- Tristate control (TSMUX):
  - 00: always Z.
  - 01: drive when TSeff=1.
  - 10: drive when TSeff=0.
  - 11: always drive.
  - TSeff = TS combinationally when SERMODE=00 and OREG=0; otherwise TS registered, with the same one-cycle latency as data.
- Bypass mode (SERMODE=00):
  - OREADY=1 constantly; OVALID is ignored and OD[0] is used each cycle.
  - OREG=0: PIN data = OD[0]^OINV combinationally (0 latency).
  - OREG=1: data = OD[0]^OINV registered (1-cycle latency).
- Serial modes (N=2 or 4):
  - FSM states IDLE and SHIFT.
  - IDLE: OREADY=1, BUSY=0, data flop = OINV (logical 0). On OVALID, capture OD[N-1:0], set cnt=N-1, go to SHIFT; bit0 appears on PIN at the next cycle.
  - SHIFT: BUSY=1; each edge presents the next bit and decrements cnt. OREADY=0 except in the cycle cnt==0.
  - At cnt==0 with OVALID=1: reload the new word back-to-back, with no gap cycle.
  - At cnt==0 with OVALID=0: return to IDLE.
- OREG is ignored in serial modes, which are always registered.
- Outputs are never X after reset.

Optional Feature:
- Macro: IOBLOCK_OUT_CFG_PARITY_EN.
- Defined:
  - CFG_BITS = 7; bit6 is odd parity over bits[6:0].
  - Added output port CFG_ERR, 1 bit, reset 0.
  - On a commit where parity is bad, active config is unchanged and CFG_ERR pulses high for 1 cycle.
- Undefined: 6-bit chain, no CFG_ERR port, no check.

Test Plan:
- Release RST -> PIN=Z, OREADY=1, BUSY=0, CFG_DOUT=0; toggling OD/TS leaves PIN at Z.
- Shift config 6'b00_0_0_11, then CFG_LOAD -> PIN follows OD[0] in the same cycle. Shift 12 bits through -> CFG_DOUT replays the first 6 bits, delayed by 6 cycles.
- Config OREG=1, OINV=1, TSMUX=11: OD[0]=1 at cycle n -> PIN=0 at n+1. Then TSMUX=01 with TS=0 -> PIN=Z one cycle after TS falls.
- SERMODE=10, TSMUX=11: OD=4'b1011 then 4'b0100, OVALID held -> PIN = 1,1,0,1,0,0,1,0 with no gap; OREADY high only in IDLE and each cnt==0 cycle.
- CFG_LOAD (new SERMODE=01) issued during the 2nd bit of a 4:1 word -> remaining bits go out 4:1, then 2:1 on the next word; RST asserted mid-word -> PIN=Z, the word is dropped.
- With IOBLOCK_OUT_CFG_PARITY_EN: load a 7-bit pattern with bad parity -> CFG_ERR=1 for one cycle, PIN behaviour unchanged.

Source files
------------

// File: rtl/ioblock_out_ser.sv
// Output IO tile: drives PIN from fabric data (bypass, registered, or 2:1/4:1 serialized),
// configured through a daisy-chained serial shadow register. Optional macro: IOBLOCK_OUT_CFG_PARITY_EN.
module ioblock_out_ser #(
  parameter int unsigned SER_W = 4
) (
  input  logic             IOCLK,
  input  logic             RST,
  inout  wire              PIN,
  input  logic [SER_W-1:0] OD,
  input  logic             OVALID,
  output logic             OREADY,
  input  logic             TS,
  output logic             BUSY,
  input  logic             CFG_EN,
  input  logic             CFG_DIN,
  output logic             CFG_DOUT,
  input  logic             CFG_LOAD
`ifdef IOBLOCK_OUT_CFG_PARITY_EN
  ,output logic            CFG_ERR
`endif
);

`ifdef IOBLOCK_OUT_CFG_PARITY_EN
  localparam int unsigned CFG_BITS = 7;
`else
  localparam int unsigned CFG_BITS = 6;
`endif
  localparam int unsigned CFG_W = 6;
  localparam int unsigned CNT_W = 2;

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  state_e              state_q, state_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_W-1:0]    active_q, active_d;
  logic                pend_q, pend_d;
  logic [SER_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dout_q, dout_d;
  logic                ts_q, ts_d;
`ifdef IOBLOCK_OUT_CFG_PARITY_EN
  logic                err_q, err_d;
`endif

  logic [1:0]       tsmux;
  logic             oreg;
  logic             oinv;
  logic [1:0]       sermode;
  logic             serial;
  logic             comb_path;
  logic [CNT_W-1:0] cnt_init;
  logic             load_req;
  logic             go_idle;
  logic             commit;
  logic             parity_ok;
  logic             pin_data;
  logic             ts_eff;
  logic             pin_oe;

  // Active config field decode
  always_comb begin
    tsmux     = active_q[1:0];
    oreg      = active_q[2];
    oinv      = active_q[3];
    sermode   = active_q[5:4];
    serial    = (sermode != 2'b00);
    comb_path = !serial && !oreg;
    cnt_init  = (sermode == 2'b01) ? CNT_W'(1) : CNT_W'(3);
  end

  // Commit happens immediately when idle, otherwise deferred to the return to IDLE
  always_comb begin
    load_req = CFG_LOAD && !CFG_EN;
    go_idle  = (state_q == S_SHIFT) && (cnt_q == '0) && !OVALID;
    commit   = (load_req && (state_q == S_IDLE)) || ((pend_q || load_req) && go_idle);
`ifdef IOBLOCK_OUT_CFG_PARITY_EN
    parity_ok = ^shadow_q;
`else
    parity_ok = 1'b1;
`endif
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    pend_d   = pend_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    ts_d     = TS;
`ifdef IOBLOCK_OUT_CFG_PARITY_EN
    err_d    = 1'b0;
`endif

    if (CFG_EN) begin
      shadow_d = {CFG_DIN, shadow_q[CFG_BITS-1:1]};
    end

    if (commit) begin
      pend_d = 1'b0;
      if (parity_ok) begin
        active_d = shadow_q[CFG_W-1:0];
      end
`ifdef IOBLOCK_OUT_CFG_PARITY_EN
      else begin
        err_d = 1'b1;
      end
`endif
    end else if (load_req) begin
      pend_d = 1'b1;
    end

    // sr_q holds the bits still to be sent; dout_q is the bit currently on the pad
    unique case (state_q)
      S_IDLE: begin
        if (!serial) begin
          dout_d = OD[0] ^ oinv;
        end else if (OVALID) begin
          sr_d    = {1'b0, OD[SER_W-1:1]};
          cnt_d   = cnt_init;
          dout_d  = OD[0] ^ oinv;
          state_d = S_SHIFT;
        end else begin
          dout_d = oinv;
        end
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          sr_d   = {1'b0, sr_q[SER_W-1:1]};
          dout_d = sr_q[0] ^ oinv;
          cnt_d  = cnt_q - CNT_W'(1);
        end else if (OVALID) begin
          sr_d   = {1'b0, OD[SER_W-1:1]};
          cnt_d  = cnt_init;
          dout_d = OD[0] ^ oinv;
        end else begin
          dout_d  = oinv;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge IOCLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      active_q <= '0;
      pend_q   <= 1'b0;
      sr_q     <= '0;
      cnt_q    <= '0;
      dout_q   <= 1'b0;
      ts_q     <= 1'b0;
`ifdef IOBLOCK_OUT_CFG_PARITY_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      ts_q     <= ts_d;
`ifdef IOBLOCK_OUT_CFG_PARITY_EN
      err_q    <= err_d;
`endif
    end
  end

  // Pad drive: combinational only in unregistered bypass
  always_comb begin
    pin_data = comb_path ? (OD[0] ^ oinv) : dout_q;
    ts_eff   = comb_path ? TS : ts_q;
    pin_oe   = 1'b0;
    unique case (tsmux)
      2'b00: pin_oe = 1'b0;
      2'b01: pin_oe = ts_eff;
      2'b10: pin_oe = !ts_eff;
      2'b11: pin_oe = 1'b1;
    endcase
  end

  assign PIN      = pin_oe ? pin_data : 1'bz;
  assign OREADY   = !RST && ((state_q == S_IDLE) || (cnt_q == '0));
  assign BUSY     = (state_q == S_SHIFT);
  assign CFG_DOUT = shadow_q[0];
`ifdef IOBLOCK_OUT_CFG_PARITY_EN
  assign CFG_ERR  = err_q;
`endif

endmodule
